// File: rtl/stream_downsize_pkg.sv
// Shared defaults, lane type and bit-count helper for the stream width converters.
package stream_pkg;

  localparam int unsigned T_DATA_WIDTH_DEF = 4;
  localparam int unsigned T_DATA_RATIO_DEF = 2;

  typedef logic [T_DATA_WIDTH_DEF-1:0] lane_t;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      cnt = cnt + {31'b0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/stream_downsize_if.sv
// Wide-in / narrow-out handshake bundle for stream_downsize.
interface stream_downsize_if #(
  parameter int unsigned T_DATA_WIDTH = 4,
  parameter int unsigned T_DATA_RATIO = 2
);

  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] s_keep_i;
  logic                    s_last_i;
  logic                    s_valid_i;
  logic                    s_ready_o;
  logic [T_DATA_WIDTH-1:0] m_data_o;
  logic                    m_last_o;
  logic                    m_valid_o;
  logic                    m_ready_i;

  modport slave (
    input  s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_last_o, m_valid_o
  );

  modport master (
    output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_last_o, m_valid_o
  );

endinterface

// File: rtl/stream_downsize_lane_sel.sv
// Lowest-set-bit encoder over the remaining-lane mask, plus a single-lane-left flag.
module stream_lane_sel
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_RATIO = T_DATA_RATIO_DEF,
  localparam int unsigned IW = $clog2(T_DATA_RATIO)
) (
  input  logic [T_DATA_RATIO-1:0] keep_i,
  output logic [IW-1:0]           idx_o,
  output logic                    single_o
);

  logic found;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < T_DATA_RATIO; i++) begin
      if (keep_i[i] && !found) begin
        idx_o = i[IW-1:0];
        found = 1'b1;
      end
    end
  end

  assign single_o = (popcount(32'(keep_i)) == 1);

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: one holding register, lanes emitted lowest index first.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = T_DATA_WIDTH_DEF,
  parameter int unsigned T_DATA_RATIO = T_DATA_RATIO_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_downsize_if.slave    bus,
  output logic                err_o
);

  localparam int unsigned IW = $clog2(T_DATA_RATIO);

  logic [T_DATA_WIDTH-1:0] hold_data_q [T_DATA_RATIO-1:0];
  logic [T_DATA_WIDTH-1:0] hold_data_d [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] rem_keep_q, rem_keep_d;
  logic                    hold_last_q, hold_last_d;
  logic                    hold_vld_q, hold_vld_d;
  logic                    err_q, err_d;

  logic [IW-1:0] sel;
  logic          single;
  logic          s_ready, s_xfer, m_xfer, load;

  stream_lane_sel #(.T_DATA_RATIO(T_DATA_RATIO)) u_lane_sel (
    .keep_i   (rem_keep_q),
    .idx_o    (sel),
    .single_o (single)
  );

  // Ready as the last lane drains lets the next wide beat load with no bubble.
  assign s_ready = ~hold_vld_q | (bus.m_ready_i & single);
  assign s_xfer  = bus.s_valid_i & s_ready;
  assign m_xfer  = hold_vld_q & bus.m_ready_i;
  assign load    = s_xfer & (|bus.s_keep_i);

  always_comb begin
    hold_data_d = hold_data_q;
    rem_keep_d  = rem_keep_q;
    hold_last_d = hold_last_q;
    hold_vld_d  = hold_vld_q;
    err_d       = s_xfer & ~(|bus.s_keep_i) & bus.s_last_i;
    if (m_xfer) begin
      rem_keep_d[sel] = 1'b0;
      if (single) hold_vld_d = 1'b0;
    end
    if (load) begin
      hold_data_d = bus.s_data_i;
      rem_keep_d  = bus.s_keep_i;
      hold_last_d = bus.s_last_i;
      hold_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < T_DATA_RATIO; i++) hold_data_q[i] <= '0;
      rem_keep_q  <= '0;
      hold_last_q <= 1'b0;
      hold_vld_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      rem_keep_q  <= rem_keep_d;
      hold_last_q <= hold_last_d;
      hold_vld_q  <= hold_vld_d;
      err_q       <= err_d;
    end
  end

  assign bus.s_ready_o = s_ready;
  assign bus.m_valid_o = hold_vld_q;
  assign bus.m_data_o  = hold_data_q[sel];
  assign bus.m_last_o  = hold_vld_q & hold_last_q & single;
  assign err_o         = err_q;

endmodule

// File: tb/tb_stream_downsize.sv
// Directed self-checking bench for stream_downsize (T_DATA_WIDTH=4, T_DATA_RATIO=2).
module tb_stream_downsize;
  import stream_pkg::*;

  logic clk;
  logic rst_n;
  logic err_o;
  int   errors;
  int   checks;

  stream_downsize_if #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) bus ();

  stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err_o (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input lane_t d1, input lane_t d0, input logic [1:0] keep,
                       input logic last, input logic valid);
    bus.s_data_i[1] = d1;
    bus.s_data_i[0] = d0;
    bus.s_keep_i    = keep;
    bus.s_last_i    = last;
    bus.s_valid_i   = valid;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
    bus.m_ready_i = 1'b1;
    step(); step();
    checks++;
    if (bus.s_ready_o !== 1'b1 || bus.m_valid_o !== 1'b0 || bus.m_last_o !== 1'b0 ||
        bus.m_data_o !== 4'h0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: rdy=%b vld=%b last=%b data=%h err=%b, want 1 0 0 0 0",
               bus.s_ready_o, bus.m_valid_o, bus.m_last_o, bus.m_data_o, err_o);
    end
    rst_n = 1'b1;
    step(); step();
    checks++;
    if (bus.s_ready_o !== 1'b1 || bus.m_valid_o !== 1'b0 || bus.m_last_o !== 1'b0 ||
        bus.m_data_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_idle: rdy=%b vld=%b last=%b data=%h, want 1 0 0 0",
               bus.s_ready_o, bus.m_valid_o, bus.m_last_o, bus.m_data_o);
    end
  endtask

  task automatic test_single_beat();
    bus.m_ready_i = 1'b1;
    drive(4'hA, 4'h5, 2'b11, 1'b1, 1'b1);
    step();
    drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
    checks++;
    if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 4'h5 || bus.m_last_o !== 1'b0 ||
        bus.s_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL pair_lane0: vld=%b data=%h last=%b rdy=%b, want 1 5 0 0",
               bus.m_valid_o, bus.m_data_o, bus.m_last_o, bus.s_ready_o);
    end
    step();
    checks++;
    if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 4'hA || bus.m_last_o !== 1'b1 ||
        bus.s_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL pair_lane1: vld=%b data=%h last=%b rdy=%b, want 1 a 1 1",
               bus.m_valid_o, bus.m_data_o, bus.m_last_o, bus.s_ready_o);
    end
    step();
    checks++;
    if (bus.m_valid_o !== 1'b0 || bus.m_last_o !== 1'b0) begin
      errors++;
      $display("FAIL pair_drain: vld=%b last=%b, want 0 0", bus.m_valid_o, bus.m_last_o);
    end
  endtask

  task automatic test_back_to_back();
    bus.m_ready_i = 1'b1;
    drive(4'h2, 4'h1, 2'b11, 1'b0, 1'b1);
    step();
    drive(4'hF, 4'h3, 2'b01, 1'b1, 1'b1);
    checks++;
    if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 4'h1 || bus.m_last_o !== 1'b0 ||
        bus.s_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: vld=%b data=%h last=%b rdy=%b, want 1 1 0 0",
               bus.m_valid_o, bus.m_data_o, bus.m_last_o, bus.s_ready_o);
    end
    step();
    checks++;
    if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 4'h2 || bus.m_last_o !== 1'b0 ||
        bus.s_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: vld=%b data=%h last=%b rdy=%b, want 1 2 0 1",
               bus.m_valid_o, bus.m_data_o, bus.m_last_o, bus.s_ready_o);
    end
    step();
    drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
    checks++;
    if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 4'h3 || bus.m_last_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_third: vld=%b data=%h last=%b, want 1 3 1",
               bus.m_valid_o, bus.m_data_o, bus.m_last_o);
    end
    step();
    checks++;
    if (bus.m_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: vld=%b, want 0", bus.m_valid_o);
    end
  endtask

  task automatic test_stall();
    bus.m_ready_i = 1'b0;
    drive(4'h7, 4'h6, 2'b11, 1'b1, 1'b1);
    step();
    drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 4'h6 || bus.m_last_o !== 1'b0 ||
          bus.s_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: vld=%b data=%h last=%b rdy=%b, want 1 6 0 0",
                 i, bus.m_valid_o, bus.m_data_o, bus.m_last_o, bus.s_ready_o);
      end
      step();
    end
    bus.m_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.m_data_o !== 4'h6 || bus.s_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: data=%h rdy=%b, want 6 0", bus.m_data_o, bus.s_ready_o);
    end
    step();
    checks++;
    if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 4'h7 || bus.m_last_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_lane1: vld=%b data=%h last=%b, want 1 7 1",
               bus.m_valid_o, bus.m_data_o, bus.m_last_o);
    end
    step();
  endtask

  task automatic test_sparse();
    bus.m_ready_i = 1'b1;
    drive(4'h9, 4'hE, 2'b10, 1'b1, 1'b1);
    step();
    drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
    checks++;
    if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 4'h9 || bus.m_last_o !== 1'b1 ||
        bus.s_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL sparse_lane1: vld=%b data=%h last=%b rdy=%b, want 1 9 1 1",
               bus.m_valid_o, bus.m_data_o, bus.m_last_o, bus.s_ready_o);
    end
    step();
    checks++;
    if (bus.m_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL sparse_drain: vld=%b, want 0", bus.m_valid_o);
    end
  endtask

  task automatic test_zero_keep();
    bus.m_ready_i = 1'b1;
    drive(4'h4, 4'h4, 2'b00, 1'b0, 1'b1);
    step();
    drive(4'h4, 4'h4, 2'b00, 1'b1, 1'b1);
    checks++;
    if (bus.m_valid_o !== 1'b0 || err_o !== 1'b0 || bus.s_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL zero_nolast: vld=%b err=%b rdy=%b, want 0 0 1",
               bus.m_valid_o, err_o, bus.s_ready_o);
    end
    step();
    drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
    checks++;
    if (bus.m_valid_o !== 1'b0 || err_o !== 1'b1 || bus.s_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL zero_err: vld=%b err=%b rdy=%b, want 0 1 1",
               bus.m_valid_o, err_o, bus.s_ready_o);
    end
    step();
    checks++;
    if (bus.m_valid_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse: vld=%b err=%b, want 0 0", bus.m_valid_o, err_o);
    end
  endtask

  task automatic test_mid_reset();
    bus.m_ready_i = 1'b1;
    drive(4'h9, 4'h8, 2'b11, 1'b1, 1'b1);
    step();
    drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
    step();
    bus.m_ready_i = 1'b0;
    #1;
    checks++;
    if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 4'h9) begin
      errors++;
      $display("FAIL mid_pending: vld=%b data=%h, want 1 9", bus.m_valid_o, bus.m_data_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.m_valid_o !== 1'b0 || bus.m_last_o !== 1'b0 || bus.m_data_o !== 4'h0 ||
        bus.s_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: vld=%b last=%b data=%h rdy=%b, want 0 0 0 1",
               bus.m_valid_o, bus.m_last_o, bus.m_data_o, bus.s_ready_o);
    end
    step();
    rst_n = 1'b1;
    bus.m_ready_i = 1'b1;
    drive(4'h4, 4'h3, 2'b11, 1'b1, 1'b1);
    step();
    drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
    checks++;
    if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 4'h3 || bus.m_last_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_lane0: vld=%b data=%h last=%b, want 1 3 0",
               bus.m_valid_o, bus.m_data_o, bus.m_last_o);
    end
    step();
    checks++;
    if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== 4'h4 || bus.m_last_o !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_lane1: vld=%b data=%h last=%b, want 1 4 1",
               bus.m_valid_o, bus.m_data_o, bus.m_last_o);
    end
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_stall();
    test_sparse();
    test_zero_keep();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
